// File: rtl/tdc_hit_encoder.sv
// tdc_hit_encoder -- multi-channel tapped-delay-line TDC hit encoder.
//
// Each channel's raw taps pass through two flop stages (S1, S2). A hit is a
// rising edge on tap 0 seen between S2 and its one-cycle-delayed copy (P0).
// The fine code is taken from the S2 taps, masked to the runtime active_taps
// window. Each hit is stamped with the coarse counter value at the edge that
// loaded the launch into S1. The hit is parked in a one-entry per-channel
// pending register, and the lowest-index occupied pending entry moves into a
// shared output FIFO each cycle.
//
// Fine code select:
//   TDC_ONES_COUNT_EN defined   : number of 1s among the masked taps (tolerates bubbles)
//   TDC_ONES_COUNT_EN undefined : index of the first 0 among the masked taps,
//                                 or active_taps if there is none
//
// Ports:
//   clk_input      sole clock, rising edge
//   rst_n          async active-low reset
//   tap_input      raw taps; channel c at [c*TAPS +: TAPS], tap 0 = launch end
//   active_taps    taps used per channel (values above TAPS clamp to TAPS)
//   ch_enable      per-channel hit-detect enable
//   hit_valid/hit_ready                     FIFO head handshake
//   hit_channel/hit_coarse/hit_fine         FIFO head fields (0 while empty)
//   overflow_count saturating count of hits dropped on a busy pending register

module tdc_ch_lane #(
  parameter int TAPS     = 256,
  parameter int COARSE_W = 16,
  parameter int FW       = 9
) (
  input  logic                clk_input,
  input  logic                rst_n,
  input  logic [TAPS-1:0]     taps,
  input  logic [FW-1:0]       act_eff,
  input  logic                enable,
  input  logic                arm,
  input  logic [COARSE_W-1:0] stamp,
  input  logic                take,
  output logic                pend_vld,
  output logic [COARSE_W-1:0] pend_coarse,
  output logic [FW-1:0]       pend_fine,
  output logic                drop
);

  logic [TAPS-1:0] s1, s2, m;
  logic            p0;
  logic            det;
  logic [FW-1:0]   fine;

  always_ff @(posedge clk_input or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      p0 <= 1'b0;
    end else begin
      s1 <= taps;
      s2 <= s1;
      p0 <= s2[0];
    end
  end

  always_comb begin
    m = '0;
    for (int i = 0; i < TAPS; i++) m[i] = s2[i] & (FW'(i) < act_eff);
  end

`ifdef TDC_ONES_COUNT_EN
  always_comb begin
    fine = '0;
    for (int i = 0; i < TAPS; i++) fine = fine + FW'(m[i]);
  end
`else
  // Taps at or above act_eff are masked to 0, so the first zero never lies
  // beyond act_eff; TAPS is left only for a fully-lit full-length line.
  always_comb begin
    fine = FW'(TAPS);
    for (int i = TAPS - 1; i >= 0; i--) if (!m[i]) fine = FW'(i);
  end
`endif

  // Detection uses the raw tap 0, so active_taps = 0 still yields a hit (fine = 0).
  assign det  = enable & arm & s2[0] & ~p0;
  // A register being vacated this edge can take the new hit.
  assign drop = det & pend_vld & ~take;

  always_ff @(posedge clk_input or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld    <= 1'b0;
      pend_coarse <= '0;
      pend_fine   <= '0;
    end else if (det && (!pend_vld || take)) begin
      pend_vld    <= 1'b1;
      pend_coarse <= stamp;
      pend_fine   <= fine;
    end else if (take) begin
      pend_vld    <= 1'b0;
    end
  end

endmodule

module tdc_hit_encoder #(
  parameter int NUM_CH     = 2,
  parameter int TAPS       = 256,
  parameter int COARSE_W   = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                 clk_input,
  input  logic                                 rst_n,
  input  logic [NUM_CH*TAPS-1:0]               tap_input,
  input  logic [$clog2(TAPS+1)-1:0]            active_taps,
  input  logic [NUM_CH-1:0]                    ch_enable,
  output logic                                 hit_valid,
  input  logic                                 hit_ready,
  output logic [((NUM_CH>1)?$clog2(NUM_CH):1)-1:0] hit_channel,
  output logic [COARSE_W-1:0]                  hit_coarse,
  output logic [$clog2(TAPS+1)-1:0]            hit_fine,
  output logic [15:0]                          overflow_count
);

  localparam int FW      = $clog2(TAPS+1);
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int STAGES  = 3;

  typedef struct packed {
    logic [CH_W-1:0]     ch;
    logic [COARSE_W-1:0] coarse;
    logic [FW-1:0]       fine;
  } hit_t;

  logic [COARSE_W-1:0]             coarse_ctr, stamp;
  logic [STAGES-1:0]               vld_pipe;
  logic [FW-1:0]                   act_eff;
  logic [NUM_CH-1:0]               pend_vld, take, drop;
  logic [NUM_CH-1:0][COARSE_W-1:0] pend_coarse;
  logic [NUM_CH-1:0][FW-1:0]       pend_fine;
  logic [CH_W-1:0]                 sel;
  logic                            any_pend, push, pop, full, push_ok;
  logic [AW:0]                     wptr, rptr;
  hit_t                            mem [FIFO_DEPTH];
  hit_t                            head, wr_ent;
  logic [16:0]                     ndrop, ovf_sum;

  always_ff @(posedge clk_input or negedge rst_n) begin
    if (!rst_n) begin
      coarse_ctr <= '0;
      vld_pipe   <= '0;
    end else begin
      coarse_ctr <= coarse_ctr + 1'b1;
      vld_pipe   <= {vld_pipe[STAGES-2:0], 1'b1};
    end
  end

  // Detection happens two edges after the S1 load, so back the counter off by 2.
  assign stamp   = coarse_ctr - COARSE_W'(2);
  assign act_eff = (active_taps > FW'(TAPS)) ? FW'(TAPS) : active_taps;

  // P0 holds a real S2 sample only after three edges out of reset; until then a
  // line that was already lit during reset must not look like a fresh launch.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    tdc_ch_lane #(.TAPS(TAPS), .COARSE_W(COARSE_W), .FW(FW)) u_lane (
      .clk_input   (clk_input),
      .rst_n       (rst_n),
      .taps        (tap_input[c*TAPS +: TAPS]),
      .act_eff     (act_eff),
      .enable      (ch_enable[c]),
      .arm         (vld_pipe[STAGES-1]),
      .stamp       (stamp),
      .take        (take[c]),
      .pend_vld    (pend_vld[c]),
      .pend_coarse (pend_coarse[c]),
      .pend_fine   (pend_fine[c]),
      .drop        (drop[c])
    );
  end

  assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign hit_valid = (wptr != rptr);
  assign pop       = hit_valid & hit_ready;
  assign push_ok   = ~full | pop;

  // Fixed priority: lowest channel index wins the single FIFO write port.
  always_comb begin
    take     = '0;
    sel      = '0;
    any_pend = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (pend_vld[c] && !any_pend) begin
        any_pend = 1'b1;
        sel      = CH_W'(c);
        take[c]  = push_ok;
      end
    end
  end

  assign push          = any_pend & push_ok;
  assign wr_ent.ch     = sel;
  assign wr_ent.coarse = pend_coarse[sel];
  assign wr_ent.fine   = pend_fine[sel];

  always_ff @(posedge clk_input) begin
    if (push) mem[wptr[AW-1:0]] <= wr_ent;
  end

  always_ff @(posedge clk_input or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage is not reset, so gate the head fields to keep them 0 while empty.
  assign head        = mem[rptr[AW-1:0]];
  assign hit_channel = hit_valid ? head.ch     : '0;
  assign hit_coarse  = hit_valid ? head.coarse : '0;
  assign hit_fine    = hit_valid ? head.fine   : '0;

  always_comb begin
    ndrop = '0;
    for (int c = 0; c < NUM_CH; c++) ndrop = ndrop + 17'(drop[c]);
  end

  assign ovf_sum = {1'b0, overflow_count} + ndrop;

  always_ff @(posedge clk_input or negedge rst_n) begin
    if (!rst_n)          overflow_count <= '0;
    else if (ovf_sum[16]) overflow_count <= 16'hFFFF;
    else                 overflow_count <= ovf_sum[15:0];
  end

endmodule

// File: tb/tb_tdc_hit_encoder.sv
// Directed bench for tdc_hit_encoder (NUM_CH=2, TAPS=256, FIFO_DEPTH=8).
// Inputs change and outputs are sampled on the falling clock edge.
// Expected coarse = number of rising edges since reset release at the moment
// the taps are driven (the counter value at the edge that samples them).

module tb_tdc_hit_encoder;

  localparam int NUM_CH = 2;
  localparam int TAPS   = 256;
  localparam int FW     = $clog2(TAPS+1);

  logic                   clk_input = 1'b0;
  logic                   rst_n;
  logic [NUM_CH*TAPS-1:0] tap_input;
  logic [FW-1:0]          active_taps;
  logic [NUM_CH-1:0]      ch_enable;
  logic                   hit_valid;
  logic                   hit_ready;
  logic [0:0]             hit_channel;
  logic [15:0]            hit_coarse;
  logic [FW-1:0]          hit_fine;
  logic [15:0]            overflow_count;

  int total = 0;
  int bad   = 0;
  logic [15:0] cyc;
  logic [15:0] ec;
  logic [15:0] ecq [10];

  tdc_hit_encoder #(.NUM_CH(NUM_CH), .TAPS(TAPS), .COARSE_W(16), .FIFO_DEPTH(8)) dut (
    .clk_input      (clk_input),
    .rst_n          (rst_n),
    .tap_input      (tap_input),
    .active_taps    (active_taps),
    .ch_enable      (ch_enable),
    .hit_valid      (hit_valid),
    .hit_ready      (hit_ready),
    .hit_channel    (hit_channel),
    .hit_coarse     (hit_coarse),
    .hit_fine       (hit_fine),
    .overflow_count (overflow_count)
  );

  always #5 clk_input = ~clk_input;

  // Edge count since reset release: the reference timebase for coarse stamps.
  always @(posedge clk_input or negedge rst_n) begin
    if (!rst_n) cyc <= '0;
    else        cyc <= cyc + 16'd1;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk_input);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int ch, input int n, input int extra);
    for (int i = 0; i < TAPS; i++) tap_input[ch*TAPS + i] = (i < n) || (i == extra);
  endtask

  // Single hit on an idle encoder: latency, fields, pop, then back to empty.
  task automatic one_hit(input string tag, input int n, input int extra, input int exp_fine);
    set_ch(0, n, extra);
    ec = cyc;
    step(3);
    chk({tag, "_early"}, 32'(hit_valid), 0);
    step(1);
    chk({tag, "_valid"}, 32'(hit_valid), 1);
    chk({tag, "_ch"},    32'(hit_channel), 0);
    chk({tag, "_fine"},  32'(hit_fine), exp_fine);
    chk({tag, "_coarse"}, 32'(hit_coarse), 32'(ec));
    tap_input = '0;
    hit_ready = 1'b1;
    step(1);
    hit_ready = 1'b0;
    chk({tag, "_popped"}, 32'(hit_valid), 0);
    step(2);
  endtask

  initial begin
    rst_n       = 1'b0;
    tap_input   = '0;
    active_taps = FW'(256);
    ch_enable   = 2'b11;
    hit_ready   = 1'b0;
    step(2);
    chk("rst_valid",  32'(hit_valid), 0);
    chk("rst_ch",     32'(hit_channel), 0);
    chk("rst_coarse", 32'(hit_coarse), 0);
    chk("rst_fine",   32'(hit_fine), 0);
    chk("rst_ovf",    32'(overflow_count), 0);
    rst_n = 1'b1;
    step(4);

    // 100 lit taps, full window; also check head holds under backpressure.
    set_ch(0, 100, -1);
    ec = cyc;
    step(3);
    chk("h100_early", 32'(hit_valid), 0);
    step(1);
    chk("h100_valid",  32'(hit_valid), 1);
    chk("h100_ch",     32'(hit_channel), 0);
    chk("h100_fine",   32'(hit_fine), 100);
    chk("h100_coarse", 32'(hit_coarse), 32'(ec));
    tap_input = '0;
    step(2);
    chk("h100_hold_valid", 32'(hit_valid), 1);
    chk("h100_hold_fine",  32'(hit_fine), 100);
    hit_ready = 1'b1;
    step(1);
    hit_ready = 1'b0;
    chk("h100_popped", 32'(hit_valid), 0);
    step(2);

    // Bubble at tap 52.
`ifdef TDC_ONES_COUNT_EN
    one_hit("bubble", 50, 52, 51);
`else
    one_hit("bubble", 50, 52, 50);
`endif

    // Window masking and clamp.
    active_taps = FW'(40);
    one_hit("act40", 100, -1, 40);
    active_taps = FW'(0);
    one_hit("act0", 100, -1, 0);
    active_taps = FW'(300);
    one_hit("act300", 100, -1, 100);
    active_taps = FW'(256);

    // Disabled channel produces nothing.
    ch_enable = 2'b10;
    set_ch(0, 100, -1);
    step(6);
    chk("dis_valid", 32'(hit_valid), 0);
    tap_input = '0;
    ch_enable = 2'b11;
    step(3);

    // Simultaneous hits on both channels, consumer always ready.
    hit_ready = 1'b1;
    set_ch(0, 10, -1);
    set_ch(1, 20, -1);
    ec = cyc;
    step(4);
    chk("dual0_valid",  32'(hit_valid), 1);
    chk("dual0_ch",     32'(hit_channel), 0);
    chk("dual0_fine",   32'(hit_fine), 10);
    chk("dual0_coarse", 32'(hit_coarse), 32'(ec));
    step(1);
    chk("dual1_valid",  32'(hit_valid), 1);
    chk("dual1_ch",     32'(hit_channel), 1);
    chk("dual1_fine",   32'(hit_fine), 20);
    chk("dual1_coarse", 32'(hit_coarse), 32'(ec));
    step(1);
    chk("dual_empty", 32'(hit_valid), 0);
    hit_ready = 1'b0;
    tap_input = '0;
    step(3);

    // Backpressure: 10 hits, 8 fill the FIFO, 1 waits pending, 1 is dropped.
    for (int k = 0; k < 10; k++) begin
      set_ch(0, 10 + k, -1);
      ecq[k] = cyc;
      step(4);
      tap_input = '0;
      step(4);
    end
    step(4);
    chk("bp_ovf",   32'(overflow_count), 1);
    chk("bp_valid", 32'(hit_valid), 1);
    hit_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("bp%0d_valid", k),  32'(hit_valid), 1);
      chk($sformatf("bp%0d_fine", k),   32'(hit_fine), 32'(10 + k));
      chk($sformatf("bp%0d_coarse", k), 32'(hit_coarse), 32'(ecq[k]));
      step(1);
    end
    chk("bp_empty", 32'(hit_valid), 0);
    hit_ready = 1'b0;
    step(2);

    // Reset in the middle of a queue of three.
    for (int k = 0; k < 3; k++) begin
      set_ch(0, 5 + k, -1);
      step(4);
      tap_input = '0;
      step(4);
    end
    chk("mid_valid", 32'(hit_valid), 1);
    chk("mid_ovf",   32'(overflow_count), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid",  32'(hit_valid), 0);
    chk("arst_ovf",    32'(overflow_count), 0);
    chk("arst_fine",   32'(hit_fine), 0);
    chk("arst_coarse", 32'(hit_coarse), 0);
    set_ch(0, 30, -1);  // launch already lit across release
    step(2);
    rst_n = 1'b1;
    step(8);
    chk("rel_valid", 32'(hit_valid), 0);
    chk("rel_ovf",   32'(overflow_count), 0);
    tap_input = '0;
    step(3);
    one_hit("resume", 60, -1, 60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
